mem_ctrl: RTL and testbench

Byte-serial memory controller that shares a single-port, 8-bit-wide synchronous RAM between the instruction-fetch stage and the MEM stage of the pipeline. It accepts one word fetch or one byte/half/word load or store at a time and sequences it as consecutive byte accesses. Read bytes are assembled little-endian, so the byte at the lowest address lands in bits 7:0. Completion is signalled with a one-cycle done pulse; the pipeline stalls the requesting stage until it sees that pulse.

---
 rtl/mem_ctrl_pkg.sv | 66 ++++++
 rtl/mem_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_mem_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared encodings and byte-lane helpers for the byte-serial memory controller.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package mem_ctrl_pkg;

  // mem_size encodings; 2'b11 also decodes as a word.
  localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    CTRL_IDLE  = 2'b00,
    CTRL_READ  = 2'b01,
    CTRL_WRITE = 2'b10,
    CTRL_DONE  = 2'b11
  } ctrl_state_t;

  // Which requester owns the transfer in flight.
  typedef enum logic {
    GRANT_IF  = 1'b0,
    GRANT_MEM = 1'b1
  } grant_t;

  // Number of byte accesses for a given access size.
  function automatic logic [2:0] byte_count(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      MEM_SIZE_BYTE: n = 3'd1;
      MEM_SIZE_HALF: n = 3'd2;
      default:       n = 3'd4;
    endcase
    return n;
  endfunction

  // Replace byte lane 'lane' of 'word' with 'b' (lane 0 = bits 7:0).
  function automatic logic [31:0] put_byte(input logic [31:0] word,
                                           input logic [1:0]  lane,
                                           input logic [7:0]  b);
    logic [31:0] w;
    w = word;
    case (lane)
      2'd0: w[7:0]   = b;
      2'd1: w[15:8]  = b;
      2'd2: w[23:16] = b;
      default: w[31:24] = b;
    endcase
    return w;
  endfunction

  // Extract byte lane 'lane' of 'word'.
  function automatic logic [7:0] get_byte(input logic [31:0] word,
                                          input logic [1:0]  lane);
    logic [7:0] b;
    case (lane)
      2'd0: b = word[7:0];
      2'd1: b = word[15:8];
      2'd2: b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: shares one 8-bit sync RAM between instruction fetch and MEM-stage loads/stores, byte-serially.
// Latency: read of n bytes -> done in cycle n+2 after accept cycle 0; write -> done in cycle n+1.
// Backpressure: one transfer at a time; requesters hold req until their one-cycle done pulse (mem wins ties).
//
// Ports:
//   clk, rst                      rising-edge clock, async active-high reset
//   if_req/if_addr                fetch request (always a word), if_inst/if_done result
//   mem_req/mem_we/mem_size/...   load/store request, mem_rdata/mem_done result
//   ram_addr/ram_we/ram_dout      RAM byte port, ram_din read byte (one cycle after address)
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_inst,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  ctrl_state_t state, state_nxt;

  // Request context latched at accept.
  grant_t              grant,   grant_nxt;
  logic                we_q,    we_nxt;
  logic [2:0]          nbytes,  nbytes_nxt;
  logic [ADDR_W-1:0]   base,    base_nxt;
  logic [31:0]         wdata_q, wdata_nxt;

  // cnt counts cycles spent in READ/WRITE, starting at 0 in the first address cycle.
  logic [2:0]          cnt,     cnt_nxt;
  logic [31:0]         asm_q,   asm_nxt;

  logic [ADDR_W-1:0]   ram_addr_nxt;
  logic                ram_we_nxt;
  logic [7:0]          ram_dout_nxt;
  logic [31:0]         if_inst_nxt;
  logic                if_done_nxt;
  logic [31:0]         mem_rdata_nxt;
  logic                mem_done_nxt;

  logic [2:0]          cnt_p1;
  logic [1:0]          cap_lane;
  logic [ADDR_W-1:0]   next_byte_addr;

  assign cnt_p1         = cnt + 3'd1;
  // The byte on ram_din now was addressed one cycle earlier, i.e. byte cnt-1.
  assign cap_lane       = cnt[1:0] - 2'd1;
  // Wraps naturally modulo 2^ADDR_W.
  assign next_byte_addr = base + {{(ADDR_W-3){1'b0}}, cnt_p1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CTRL_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // All outputs are computed one cycle ahead here and registered below.
  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    we_nxt        = we_q;
    nbytes_nxt    = nbytes;
    base_nxt      = base;
    wdata_nxt     = wdata_q;
    cnt_nxt       = cnt;
    asm_nxt       = asm_q;
    ram_addr_nxt  = '0;
    ram_we_nxt    = WRITE_DISABLE;
    ram_dout_nxt  = 8'h00;
    if_inst_nxt   = if_inst;
    if_done_nxt   = 1'b0;
    mem_rdata_nxt = mem_rdata;
    mem_done_nxt  = 1'b0;

    case (state)
      CTRL_IDLE: begin
        cnt_nxt = 3'd0;
        asm_nxt = 32'h0;
        if (mem_req) begin
          // The MEM-stage instruction is older than the one being fetched.
          grant_nxt    = GRANT_MEM;
          we_nxt       = mem_we;
          nbytes_nxt   = byte_count(mem_size);
          base_nxt     = mem_addr;
          wdata_nxt    = mem_wdata;
          ram_addr_nxt = mem_addr;
          if (mem_we) begin
            ram_we_nxt   = WRITE_ENABLE;
            ram_dout_nxt = mem_wdata[7:0];
            state_nxt    = CTRL_WRITE;
          end else begin
            state_nxt    = CTRL_READ;
          end
        end else if (if_req) begin
          grant_nxt    = GRANT_IF;
          we_nxt       = 1'b0;
          nbytes_nxt   = 3'd4;
          base_nxt     = if_addr;
          wdata_nxt    = 32'h0;
          ram_addr_nxt = if_addr;
          state_nxt    = CTRL_READ;
        end
      end

      CTRL_READ: begin
        cnt_nxt = cnt_p1;
        if (cnt != 3'd0) begin
          asm_nxt = put_byte(asm_q, cap_lane, ram_din);
        end
        if (cnt_p1 < nbytes) begin
          ram_addr_nxt = next_byte_addr;
        end
        // Last byte arrives one cycle after the last address cycle.
        if (cnt == nbytes) begin
          state_nxt = CTRL_DONE;
          if (grant == GRANT_MEM) begin
            mem_rdata_nxt = asm_nxt;
            mem_done_nxt  = 1'b1;
          end else begin
            if_inst_nxt   = asm_nxt;
            if_done_nxt   = 1'b1;
          end
        end
      end

      CTRL_WRITE: begin
        cnt_nxt = cnt_p1;
        if (cnt_p1 < nbytes) begin
          ram_addr_nxt = next_byte_addr;
          ram_we_nxt   = WRITE_ENABLE;
          ram_dout_nxt = get_byte(wdata_q, cnt_p1[1:0]);
        end else begin
          state_nxt    = CTRL_DONE;
          mem_done_nxt = 1'b1;
        end
      end

      CTRL_DONE: begin
        // Requests are not looked at here, so a requester still holding
        // req in this cycle is not accepted twice.
        state_nxt = CTRL_IDLE;
      end

      default: state_nxt = CTRL_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant     <= GRANT_IF;
      we_q      <= 1'b0;
      nbytes    <= 3'd0;
      base      <= '0;
      wdata_q   <= 32'h0;
      cnt       <= 3'd0;
      asm_q     <= 32'h0;
      ram_addr  <= '0;
      ram_we    <= WRITE_DISABLE;
      ram_dout  <= 8'h00;
      if_inst   <= 32'h0;
      if_done   <= 1'b0;
      mem_rdata <= 32'h0;
      mem_done  <= 1'b0;
    end else begin
      grant     <= grant_nxt;
      we_q      <= we_nxt;
      nbytes    <= nbytes_nxt;
      base      <= base_nxt;
      wdata_q   <= wdata_nxt;
      cnt       <= cnt_nxt;
      asm_q     <= asm_nxt;
      ram_addr  <= ram_addr_nxt;
      ram_we    <= ram_we_nxt;
      ram_dout  <= ram_dout_nxt;
      if_inst   <= if_inst_nxt;
      if_done   <= if_done_nxt;
      mem_rdata <= mem_rdata_nxt;
      mem_done  <= mem_done_nxt;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed bench for mem_ctrl with a behavioural 8-bit sync RAM.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_inst;
  logic        if_done;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic [31:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;

  int nvec = 0;
  int nmis = 0;

  // RAM model: 4 KiB, indexed by the low 12 address bits. Preload port shares the write process.
  logic [7:0]  ram [0:4095];
  logic        pl_we = 1'b0;
  logic [11:0] pl_addr = 12'h0;
  logic [7:0]  pl_dat = 8'h0;

  logic [31:0] tr_addr [0:31];
  logic        tr_we   [0:31];
  logic [7:0]  tr_dout [0:31];

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_inst(if_inst), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_dout(ram_dout), .ram_din(ram_din)
  );

  always @(posedge clk) begin
    ram_din <= ram[ram_addr[11:0]];
    if (ram_we) ram[ram_addr[11:0]] <= ram_dout;
    else if (pl_we) ram[pl_addr] <= pl_dat;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_dat = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // Raises one request in an IDLE cycle (cycle 0) and traces RAM port until done.
  task automatic issue(input bit fetch, input bit we, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output int done_cyc, output logic [31:0] data);
    done_cyc = -1;
    data = 32'h0;
    @(negedge clk);
    if (fetch) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      mem_req = 1'b1; mem_we = we; mem_size = size; mem_addr = addr; mem_wdata = wdata;
    end
    for (int c = 1; c < 20 && done_cyc < 0; c++) begin
      @(negedge clk);
      tr_addr[c] = ram_addr; tr_we[c] = ram_we; tr_dout[c] = ram_dout;
      if ((fetch && if_done) || (!fetch && mem_done)) begin
        done_cyc = c;
        data = fetch ? if_inst : mem_rdata;
      end
    end
    if_req = 1'b0;
    mem_req = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    nvec++;
    if ({if_inst, if_done, mem_rdata, mem_done} !== 66'h0) begin
      nmis++; $display("FAIL reset_data: got %h/%b/%h/%b want 0", if_inst, if_done, mem_rdata, mem_done);
    end
    nvec++;
    if ({ram_addr, ram_we, ram_dout} !== 41'h0) begin
      nmis++; $display("FAIL reset_ram: got addr=%h we=%b dout=%h want 0", ram_addr, ram_we, ram_dout);
    end
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    int dc; logic [31:0] d;
    issue(1'b1, 1'b0, 2'd2, 32'h100, 32'h0, dc, d);
    nvec++; if (dc !== 6) begin nmis++; $display("FAIL fetch_cycle: got %0d want 6", dc); end
    nvec++; if (d !== 32'h00100513) begin nmis++; $display("FAIL fetch_inst: got %h want 00100513", d); end
    for (int k = 0; k < 4; k++) begin
      nvec++;
      if (tr_addr[k+1] !== 32'h100 + k || tr_we[k+1] !== 1'b0) begin
        nmis++; $display("FAIL fetch_addr%0d: got %h we=%b want %h we=0", k, tr_addr[k+1], tr_we[k+1], 32'h100 + k);
      end
    end
    nvec++; if (tr_addr[6] !== 32'h0) begin nmis++; $display("FAIL fetch_done_addr: got %h want 0", tr_addr[6]); end
    @(negedge clk);
    nvec++; if (if_done !== 1'b0) begin nmis++; $display("FAIL fetch_pulse_width: if_done=%b in cycle 7 want 0", if_done); end
    nvec++; if (mem_rdata !== 32'h0) begin nmis++; $display("FAIL fetch_mem_hold: mem_rdata=%h want 0", mem_rdata); end
  endtask

  task automatic test_load_sizes();
    int dc; logic [31:0] d;
    issue(1'b0, 1'b0, 2'd0, 32'h203, 32'h0, dc, d);
    nvec++; if (dc !== 3) begin nmis++; $display("FAIL lb_cycle: got %0d want 3", dc); end
    nvec++; if (d !== 32'h000000F0) begin nmis++; $display("FAIL lb_data: got %h want 000000f0", d); end
    nvec++; if (if_inst !== 32'h00100513) begin nmis++; $display("FAIL lb_if_hold: if_inst=%h want 00100513", if_inst); end
    issue(1'b0, 1'b0, 2'd1, 32'h1FF, 32'h0, dc, d);
    nvec++; if (dc !== 4) begin nmis++; $display("FAIL lh_cycle: got %0d want 4", dc); end
    nvec++; if (d !== 32'h00001234) begin nmis++; $display("FAIL lh_data: got %h want 00001234", d); end
    nvec++;
    if (tr_addr[1] !== 32'h1FF || tr_addr[2] !== 32'h200) begin
      nmis++; $display("FAIL lh_addr: got %h,%h want 000001ff,00000200", tr_addr[1], tr_addr[2]);
    end
  endtask

  task automatic test_store_load();
    int dc; logic [31:0] d;
    logic [31:0] wv;
    wv = 32'hDEADBEEF;
    issue(1'b0, 1'b1, 2'd2, 32'h400, wv, dc, d);
    nvec++; if (dc !== 5) begin nmis++; $display("FAIL sw_cycle: got %0d want 5", dc); end
    for (int k = 0; k < 4; k++) begin
      nvec++;
      if (tr_we[k+1] !== 1'b1 || tr_addr[k+1] !== 32'h400 + k || tr_dout[k+1] !== wv[8*k +: 8]) begin
        nmis++; $display("FAIL sw_byte%0d: got we=%b addr=%h dout=%h want we=1 addr=%h dout=%h",
                         k, tr_we[k+1], tr_addr[k+1], tr_dout[k+1], 32'h400 + k, wv[8*k +: 8]);
      end
    end
    nvec++;
    if (tr_we[5] !== 1'b0 || tr_addr[5] !== 32'h0 || tr_dout[5] !== 8'h0) begin
      nmis++; $display("FAIL sw_done_port: got we=%b addr=%h dout=%h want 0", tr_we[5], tr_addr[5], tr_dout[5]);
    end
    issue(1'b0, 1'b0, 2'd3, 32'h400, 32'h0, dc, d);
    nvec++; if (dc !== 6) begin nmis++; $display("FAIL lw_cycle: got %0d want 6", dc); end
    nvec++; if (d !== 32'hDEADBEEF) begin nmis++; $display("FAIL lw_data: got %h want deadbeef", d); end
  endtask

  task automatic test_wrap();
    int dc; logic [31:0] d;
    logic [31:0] exp_a [0:3];
    exp_a[0] = 32'hFFFFFFFE; exp_a[1] = 32'hFFFFFFFF; exp_a[2] = 32'h0; exp_a[3] = 32'h1;
    issue(1'b0, 1'b0, 2'd2, 32'hFFFFFFFE, 32'h0, dc, d);
    for (int k = 0; k < 4; k++) begin
      nvec++;
      if (tr_addr[k+1] !== exp_a[k]) begin
        nmis++; $display("FAIL wrap_addr%0d: got %h want %h", k, tr_addr[k+1], exp_a[k]);
      end
    end
    nvec++; if (d !== 32'hD4C3B2A1) begin nmis++; $display("FAIL wrap_data: got %h want d4c3b2a1", d); end
  endtask

  task automatic test_back_to_back();
    int md, id;
    logic [31:0] mdat, idat;
    md = -1; id = -1; mdat = 32'h0; idat = 32'h0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_addr = 32'h300;
    for (int c = 1; c < 32 && id < 0; c++) begin
      @(negedge clk);
      tr_addr[c] = ram_addr;
      if (mem_done) begin md = c; mdat = mem_rdata; mem_req = 1'b0; end
      if (if_done) begin id = c; idat = if_inst; if_req = 1'b0; end
    end
    if_req = 1'b0; mem_req = 1'b0;
    nvec++; if (md !== 6) begin nmis++; $display("FAIL b2b_mem_cycle: got %0d want 6", md); end
    nvec++; if (mdat !== 32'h12345678) begin nmis++; $display("FAIL b2b_mem_data: got %h want 12345678", mdat); end
    nvec++; if (tr_addr[8] !== 32'h100) begin nmis++; $display("FAIL b2b_fetch_start: cycle8 addr=%h want 00000100", tr_addr[8]); end
    nvec++; if (id !== 13) begin nmis++; $display("FAIL b2b_if_cycle: got %0d want 13", id); end
    nvec++; if (idat !== 32'h00100513) begin nmis++; $display("FAIL b2b_if_data: got %h want 00100513", idat); end
  endtask

  task automatic test_reset_mid_store();
    int dc, ndone; logic [31:0] d;
    logic [7:0] got [0:3];
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd2; mem_addr = 32'h500; mem_wdata = 32'h11223344;
    @(posedge clk);  // cycle 1 begins
    @(posedge clk);  // cycle 2
    @(posedge clk);  // cycle 3
    #1 rst = 1'b1;
    #1;
    nvec++;
    if ({ram_addr, ram_we, ram_dout, if_done, mem_done, mem_rdata, if_inst} !== 107'h0) begin
      nmis++; $display("FAIL rst_mid_outputs: addr=%h we=%b dout=%h mem_done=%b want all 0", ram_addr, ram_we, ram_dout, mem_done);
    end
    mem_req = 1'b0;
    ndone = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mem_done) ndone++;
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mem_done) ndone++;
    end
    nvec++; if (ndone !== 0) begin nmis++; $display("FAIL rst_mid_no_done: got %0d pulses want 0", ndone); end
    for (int k = 0; k < 4; k++) got[k] = ram[12'h500 + k];
    nvec++;
    if ({got[0], got[1], got[2], got[3]} !== 32'h44330000) begin
      nmis++; $display("FAIL rst_mid_ram: got %h %h %h %h want 44 33 00 00", got[0], got[1], got[2], got[3]);
    end
    issue(1'b0, 1'b1, 2'd2, 32'h500, 32'h11223344, dc, d);
    nvec++; if (dc !== 5) begin nmis++; $display("FAIL rst_retry_cycle: got %0d want 5", dc); end
    @(negedge clk);
    for (int k = 0; k < 4; k++) got[k] = ram[12'h500 + k];
    nvec++;
    if ({got[0], got[1], got[2], got[3]} !== 32'h44332211) begin
      nmis++; $display("FAIL rst_retry_ram: got %h %h %h %h want 44 33 22 11", got[0], got[1], got[2], got[3]);
    end
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = 32'h0;
    mem_req = 1'b0; mem_we = 1'b0; mem_size = 2'd0; mem_addr = 32'h0; mem_wdata = 32'h0;
    for (int i = 0; i < 32; i++) begin tr_addr[i] = 32'h0; tr_we[i] = 1'b0; tr_dout[i] = 8'h0; end
    test_reset();
    poke(12'h100, 8'h13); poke(12'h101, 8'h05); poke(12'h102, 8'h10); poke(12'h103, 8'h00);
    poke(12'h203, 8'hF0); poke(12'h1FF, 8'h34); poke(12'h200, 8'h12);
    poke(12'h300, 8'h78); poke(12'h301, 8'h56); poke(12'h302, 8'h34); poke(12'h303, 8'h12);
    poke(12'hFFE, 8'hA1); poke(12'hFFF, 8'hB2); poke(12'h000, 8'hC3); poke(12'h001, 8'hD4);
    for (int k = 0; k < 4; k++) poke(12'h400 + k[11:0], 8'h00);
    for (int k = 0; k < 4; k++) poke(12'h500 + k[11:0], 8'h00);
    test_fetch();
    test_load_sizes();
    test_store_load();
    test_wrap();
    test_back_to_back();
    test_reset_mid_store();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
